vscale_htif_pcr_arbiter: RTL and testbench

- Shares the single vscale_top HTIF PCR request/response port among NUM_REQ host-side requesters, for example a tohost poller plus a debug CSR writer.
- Issues exactly one PCR transaction at a time.
- Selects requesters round-robin and routes each PCR response back to the requester that was granted.
- Sits between the host/testbench agents and the core's htif_pcr_* pins.

---
 rtl/vscale_htif_pcr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_vscale_htif_pcr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_arbiter.sv
// Round-robin arbiter sharing the vscale HTIF PCR port among NUM_REQ host requesters.
// Optional response watchdog enabled by defining VSCALE_HTIF_ARB_TIMEOUT_EN.
module vscale_htif_pcr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            up_req_valid,
    output logic [NUM_REQ-1:0]            up_req_ready,
    input  logic [NUM_REQ-1:0]            up_req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] up_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] up_req_data,
    output logic [NUM_REQ-1:0]            up_resp_valid,
    input  logic [NUM_REQ-1:0]            up_resp_ready,
    output logic [DATA_WIDTH-1:0]         up_resp_data,
    output logic                          htif_pcr_req_valid,
    input  logic                          htif_pcr_req_ready,
    output logic                          htif_pcr_req_rw,
    output logic [ADDR_WIDTH-1:0]         htif_pcr_req_addr,
    output logic [DATA_WIDTH-1:0]         htif_pcr_req_data,
    input  logic                          htif_pcr_resp_valid,
    output logic                          htif_pcr_resp_ready,
    input  logic [DATA_WIDTH-1:0]         htif_pcr_resp_data,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("vscale_htif_pcr_arbiter: parameter out of range");
    end

    state_t state;
    logic [GW-1:0] last_grant;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 win_oh;
    logic [NUM_REQ-1:0]                 grant_oh;
    logic                               win_vld;
    logic [GW-1:0]                      win_id;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign req_addr[i] = up_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_data[i] = up_req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign win_oh[i]   = win_vld && (win_id == GW'(i));
        assign grant_oh[i] = (grant_id == GW'(i));
    end

    // Circular scan starting just after the last served requester.
    always_comb begin
        int s;
        win_vld = 1'b0;
        win_id  = '0;
        s       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = (int'(last_grant) + k) % NUM_REQ;
            if (!win_vld && up_req_valid[s]) begin
                win_vld = 1'b1;
                win_id  = GW'(s);
            end
        end
    end

    // Ready is held low while reset is asserted so no request slips in.
    assign up_req_ready = (reset && state == S_IDLE) ? win_oh : '0;

`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    logic [TW-1:0] wait_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= S_IDLE;
            last_grant          <= GW'(NUM_REQ - 1);
            grant_id            <= '0;
            busy                <= 1'b0;
            htif_pcr_req_valid  <= 1'b0;
            htif_pcr_req_rw     <= 1'b0;
            htif_pcr_req_addr   <= '0;
            htif_pcr_req_data   <= '0;
            htif_pcr_resp_ready <= 1'b0;
            up_resp_valid       <= '0;
            up_resp_data        <= '0;
`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
            wait_cnt            <= '0;
            timeout_err         <= 1'b0;
`endif
        end else begin
`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_id           <= win_id;
                        htif_pcr_req_rw    <= up_req_rw[win_id];
                        htif_pcr_req_addr  <= req_addr[win_id];
                        htif_pcr_req_data  <= req_data[win_id];
                        htif_pcr_req_valid <= 1'b1;
                        busy               <= 1'b1;
                        state              <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (htif_pcr_req_ready) begin
                        htif_pcr_req_valid  <= 1'b0;
                        htif_pcr_resp_ready <= 1'b1;
`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
                        wait_cnt            <= '0;
`endif
                        state               <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Writes wait for the core's acknowledge just like reads.
                    if (htif_pcr_resp_valid) begin
                        up_resp_data        <= htif_pcr_resp_data;
                        htif_pcr_resp_ready <= 1'b0;
                        up_resp_valid       <= grant_oh;
                        state               <= S_RETURN;
                    end
`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        up_resp_data        <= '1;
                        htif_pcr_resp_ready <= 1'b0;
                        up_resp_valid       <= grant_oh;
                        timeout_err         <= 1'b1;
                        state               <= S_RETURN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RETURN: begin
                    if (up_resp_ready[grant_id]) begin
                        up_resp_valid <= '0;
                        last_grant    <= grant_id;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed + randomized bench for vscale_htif_pcr_arbiter with a round-robin scoreboard.
module tb_vscale_htif_pcr_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      up_req_valid, up_req_ready, up_req_rw;
    logic [N*AW-1:0]   up_req_addr;
    logic [N*DW-1:0]   up_req_data;
    logic [N-1:0]      up_resp_valid, up_resp_ready;
    logic [DW-1:0]     up_resp_data;
    logic              htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
    logic [AW-1:0]     htif_pcr_req_addr;
    logic [DW-1:0]     htif_pcr_req_data;
    logic              htif_pcr_resp_valid, htif_pcr_resp_ready;
    logic [DW-1:0]     htif_pcr_resp_data;
    logic [GW-1:0]     grant_id;
    logic              busy, timeout_err;

    vscale_htif_pcr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_rw(up_req_rw),
        .up_req_addr(up_req_addr), .up_req_data(up_req_data),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_data(up_resp_data),
        .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
        .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
        .htif_pcr_req_data(htif_pcr_req_data),
        .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
        .htif_pcr_resp_data(htif_pcr_resp_data),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side model: what each requester is currently presenting.
    logic [N-1:0]  pend;
    logic          m_rw   [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];
    int            m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            up_req_valid[i]          = pend[i];
            up_req_rw[i]             = m_rw[i];
            up_req_addr[i*AW +: AW]  = m_addr[i];
            up_req_data[i*DW +: DW]  = m_data[i];
        end
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_rw[i] = rw; m_addr[i] = a; m_data[i] = d; pend[i] = 1'b1;
        drive_reqs();
    endtask

    // Next pending requester after the last one served, wrapping around.
    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Runs one whole transaction from IDLE; called #1 after a posedge with requests driven.
    task automatic run_txn(input int id, input logic [DW-1:0] rdata, input int rq_st,
                           input int rs_st, input int up_st, input bit drop);
        logic [N-1:0] oh;
        oh = '0; oh[id] = 1'b1;
        #1;
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("req_ready", {61'd0, up_req_ready}, {61'd0, oh});
        @(posedge clk); #1;
        if (drop) begin pend[id] = 1'b0; drive_reqs(); end
        for (int s = 0; s <= rq_st; s++) begin
            htif_pcr_req_ready = (s == rq_st);
            #1;
            chk("issue_valid", {63'd0, htif_pcr_req_valid}, 64'd1);
            chk("issue_rw", {63'd0, htif_pcr_req_rw}, {63'd0, m_rw[id]});
            chk("issue_addr", {52'd0, htif_pcr_req_addr}, {52'd0, m_addr[id]});
            chk("issue_data", htif_pcr_req_data, m_data[id]);
            chk("issue_grant", {62'd0, grant_id}, 64'(id));
            chk("issue_noready", {61'd0, up_req_ready}, 64'd0);
            @(posedge clk); #1;
        end
        htif_pcr_req_ready = 1'b0;
        for (int s = 0; s <= rs_st; s++) begin
            htif_pcr_resp_valid = (s == rs_st);
            htif_pcr_resp_data  = (s == rs_st) ? rdata : {$urandom, $urandom};
            #1;
            chk("wait_resp_ready", {63'd0, htif_pcr_resp_ready}, 64'd1);
            chk("wait_no_up_resp", {61'd0, up_resp_valid}, 64'd0);
            chk("wait_req_valid", {63'd0, htif_pcr_req_valid}, 64'd0);
            @(posedge clk); #1;
        end
        htif_pcr_resp_valid = 1'b0;
        htif_pcr_resp_data  = {$urandom, $urandom};
        for (int s = 0; s <= up_st; s++) begin
            up_resp_ready = (s == up_st) ? oh : ~oh;
            #1;
            chk("ret_valid", {61'd0, up_resp_valid}, {61'd0, oh});
            chk("ret_data", up_resp_data, rdata);
            chk("ret_resp_ready", {63'd0, htif_pcr_resp_ready}, 64'd0);
            @(posedge clk); #1;
        end
        up_resp_ready = '0;
        #1;
        chk("done_valid", {61'd0, up_resp_valid}, 64'd0);
        chk("done_busy", {63'd0, busy}, 64'd0);
        m_last = id;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        reset = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) begin m_rw[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; end
        drive_reqs();
        up_resp_ready = '0; htif_pcr_req_ready = 1'b0;
        htif_pcr_resp_valid = 1'b0; htif_pcr_resp_data = '0;
        m_last = N - 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_grant", {62'd0, grant_id}, 64'd0);
        chk("rst_req_valid", {63'd0, htif_pcr_req_valid}, 64'd0);
        chk("rst_resp_ready", {63'd0, htif_pcr_resp_ready}, 64'd0);
        chk("rst_up_valid", {61'd0, up_resp_valid}, 64'd0);
        chk("rst_up_ready", {61'd0, up_req_ready}, 64'd0);
        chk("rst_up_data", up_resp_data, 64'd0);
        chk("rst_addr", {52'd0, htif_pcr_req_addr}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single read with minimum latency.
        set_req(0, 1'b0, 12'h780, 64'd0);
        run_txn(0, 64'd144, 0, 0, 0, 1'b1);
        // Write from requester 1.
        set_req(1, 1'b1, 12'h51E, 64'hDEAD_BEEF);
        run_txn(1, 64'h0, 0, 1, 0, 1'b1);
        // Contention: 0 and 1 held valid throughout.
        set_req(0, 1'b0, 12'h100, 64'h11);
        set_req(1, 1'b1, 12'h101, 64'h22);
        run_txn(0, 64'hA0, 0, 0, 0, 1'b0);
        run_txn(1, 64'hA1, 0, 0, 0, 1'b0);
        run_txn(0, 64'hA2, 1, 0, 0, 1'b0);
        run_txn(1, 64'hA3, 0, 2, 0, 1'b0);
        pend = '0; drive_reqs();
        // Backpressure on both sides.
        set_req(1, 1'b0, 12'h342, 64'h55AA);
        run_txn(1, 64'hCAFE_F00D_1234_5678, 5, 2, 3, 1'b1);
        // Make requester 0 the last served, then reset mid-WAIT.
        set_req(0, 1'b0, 12'h7C0, 64'h0);
        run_txn(0, 64'h77, 0, 0, 0, 1'b1);
        set_req(0, 1'b0, 12'h7C1, 64'h0);
        #1 chk("mid_ready", {61'd0, up_req_ready}, 64'd1);
        @(posedge clk); #1;
        pend[0] = 1'b0; drive_reqs();
        htif_pcr_req_ready = 1'b1;
        @(posedge clk); #1;
        htif_pcr_req_ready = 1'b0;
        #1 chk("mid_in_wait", {63'd0, htif_pcr_resp_ready}, 64'd1);
        reset = 1'b0;
        htif_pcr_resp_valid = 1'b1; htif_pcr_resp_data = 64'h99;
        @(posedge clk); #1;
        reset = 1'b1;
        htif_pcr_resp_valid = 1'b0;
        #1;
        chk("mrst_busy", {63'd0, busy}, 64'd0);
        chk("mrst_up_valid", {61'd0, up_resp_valid}, 64'd0);
        chk("mrst_resp_ready", {63'd0, htif_pcr_resp_ready}, 64'd0);
        chk("mrst_grant", {62'd0, grant_id}, 64'd0);
        chk("mrst_data", up_resp_data, 64'd0);
        m_last = N - 1;
        set_req(0, 1'b1, 12'h010, 64'h1);
        set_req(1, 1'b1, 12'h011, 64'h2);
        run_txn(0, 64'h5, 0, 0, 0, 1'b1);
        run_txn(1, 64'h6, 0, 0, 0, 1'b1);

        // Randomized traffic against the round-robin model.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), {$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) begin
                id = $urandom_range(0, N - 1);
                pend[id] = 1'b0;
                drive_reqs();
            end
            if (pend == '0)
                set_req($urandom_range(0, N - 1), 1'b0, AW'($urandom), {$urandom, $urandom});
            id = rr_pick(pend, m_last);
            run_txn(id, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2), 1'b1);
        end

`ifdef VSCALE_HTIF_ARB_TIMEOUT_EN
        begin
            int waits;
            bit seen;
            pend = '0;
            set_req(2, 1'b0, 12'h0AB, 64'h0);
            id = rr_pick(pend, m_last);
            #1 chk("to_req_ready", {61'd0, up_req_ready}, 64'd4);
            @(posedge clk); #1;
            pend = '0; drive_reqs();
            htif_pcr_req_ready = 1'b1;
            @(posedge clk); #1;
            htif_pcr_req_ready = 1'b0;
            waits = 0; seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                #1;
                if (up_resp_valid != '0) seen = 1'b1;
                else begin
                    if (htif_pcr_resp_ready) waits++;
                    @(posedge clk); #1;
                end
            end
            chk("to_seen", {63'd0, seen}, 64'd1);
            chk("to_wait_cycles", 64'(waits), 64'd10);
            chk("to_pulse", {63'd0, timeout_err}, 64'd1);
            chk("to_data", up_resp_data, '1);
            chk("to_valid", {61'd0, up_resp_valid}, 64'd4);
            htif_pcr_resp_valid = 1'b1;
            @(posedge clk); #1;
            chk("to_pulse_once", {63'd0, timeout_err}, 64'd0);
            chk("to_late_ignored", {63'd0, htif_pcr_resp_ready}, 64'd0);
            up_resp_ready = 3'b100;
            @(posedge clk); #1;
            up_resp_ready = '0;
            htif_pcr_resp_valid = 1'b0;
            #1 chk("to_idle", {63'd0, busy}, 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
